// File: rtl/flash_read_arbiter.sv
// Two-port arbiter sharing one SPI flash: each accepted request runs a READ (0x03)
// transaction (command, 24-bit address, 32 data bits) and returns the word to its requester.
module flash_read_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  input  logic [23:0] req0_addr_i,
  output logic        req0_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_rdata_o,
  input  logic        req1_valid_i,
  input  logic [23:0] req1_addr_i,
  output logic        req1_ready_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_rdata_o,
  output logic        sck_o,
  output logic        sdo_o,
  input  logic        sdi_i,
  output logic        cs_no,
  output logic        busy_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((CS_GAP > 2) ? CS_GAP - 2 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE, ST_GAP} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [5:0]    bit_q;
  logic [31:0]   shift_q;
  logic [31:0]   rx_q;
  logic [GW-1:0] gap_q;
  logic          sck_q, sdo_q, cs_q;
  logic          owner_q, last_q;
  logic          rv0_q, rv1_q;
  logic [31:0]   rd0_q, rd1_q;

  logic        idle, grant0, grant1, accept;
  logic        phase_end, bit_end, last_bit;
  logic [31:0] cmd_word;
  logic [31:0] rx_word;

  assign idle   = (state_q == ST_IDLE);
  assign grant0 = req0_valid_i & (~req1_valid_i | last_q);
  assign grant1 = req1_valid_i & (~req0_valid_i | ~last_q);

  // Ready is held low while reset is asserted so nothing can look accepted during reset.
  assign req0_ready_o = rst_ni & idle & grant0;
  assign req1_ready_o = rst_ni & idle & grant1;
  assign accept       = req0_ready_o | req1_ready_o;

  assign cmd_word  = {8'h03, req1_ready_o ? req1_addr_i : req0_addr_i};
  assign phase_end = (div_q == DIV_LAST);
  assign bit_end   = phase_end & sck_q;
  assign last_bit  = (bit_q == 6'd63);

  // Bytes arrive lowest address first, so the first byte lands in bits [7:0].
  assign rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_end && last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = (CS_GAP > 1) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      cs_q    <= 1'b1;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= req1_ready_o;
            last_q  <= req1_ready_o;
            shift_q <= cmd_word;
            sdo_q   <= cmd_word[31];
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (phase_end) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              // Only the last 32 bit slots carry read data.
              if (bit_q[5]) rx_q <= {rx_q[30:0], sdi_i};
            end else begin
              sck_q <= 1'b0;
              if (last_bit) begin
                cs_q  <= 1'b1;
                sdo_q <= 1'b0;
                if (owner_q) begin
                  rv1_q <= 1'b1;
                  rd1_q <= rx_word;
                end else begin
                  rv0_q <= 1'b1;
                  rd0_q <= rx_word;
                end
              end else begin
                bit_q   <= bit_q + 6'd1;
                shift_q <= {shift_q[30:0], 1'b0};
                sdo_q   <= shift_q[30];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_DONE: gap_q <= GAP_LOAD;
        ST_GAP:  gap_q <= gap_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign sck_o        = sck_q;
  assign sdo_o        = sdo_q;
  assign cs_no        = cs_q;
  assign busy_o       = ~idle;
  assign rsp0_valid_o = rv0_q;
  assign rsp1_valid_o = rv1_q;
  assign rsp0_rdata_o = rd0_q;
  assign rsp1_rdata_o = rd1_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: two instances (CLK_DIV=2/CS_GAP=4 and CLK_DIV=1/CS_GAP=1),
// an SPI flash model per instance, and a transaction-level predictor checked every cycle.
module tb_flash_read_arbiter;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic        v0 [2];
  logic        v1 [2];
  logic [23:0] a0 [2];
  logic [23:0] a1 [2];
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        sck [2];
  logic        sdo [2];
  logic        cs [2];
  logic        busy [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Flash contents: a small block at 0x200000 holds 13 00 00 00, elsewhere byte = addr[7:0]+0x40.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (a[23:16] == 8'h20) return (a == 24'h200000) ? 8'h13 : 8'h00;
    return a[7:0] + 8'h40;
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {fbyte(24'(a + 24'd3)), fbyte(24'(a + 24'd2)), fbyte(24'(a + 24'd1)), fbyte(a)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    int          fcnt = 0;
    logic [31:0] fcap = '0;
    logic        sdi_g;

    flash_read_arbiter #(
      .CLK_DIV(g == 0 ? 2 : 1),
      .CS_GAP (g == 0 ? 4 : 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req0_valid_i(v0[g]),
      .req0_addr_i (a0[g]),
      .req0_ready_o(rdy0[g]),
      .rsp0_valid_o(rv0[g]),
      .rsp0_rdata_o(rd0[g]),
      .req1_valid_i(v1[g]),
      .req1_addr_i (a1[g]),
      .req1_ready_o(rdy1[g]),
      .rsp1_valid_o(rv1[g]),
      .rsp1_rdata_o(rd1[g]),
      .sck_o       (sck[g]),
      .sdo_o       (sdo[g]),
      .sdi_i       (sdi_g),
      .cs_no       (cs[g]),
      .busy_o      (busy[g])
    );

    // Flash side: capture command+address on SCK rise, present data bits MSB first per byte.
    always @(posedge sck[g] or posedge cs[g]) begin
      if (cs[g]) fcnt <= 0;
      else begin
        if (fcnt < 32) fcap <= {fcap[30:0], sdo[g]};
        fcnt <= fcnt + 1;
      end
    end

    always_comb begin
      logic [7:0] b;
      int j;
      b     = 8'h00;
      j     = 0;
      sdi_g = 1'b0;
      if (!cs[g] && fcnt >= 32 && fcnt < 64) begin
        j     = fcnt - 32;
        b     = fbyte(24'(fcap[23:0] + 24'(j / 8)));
        sdi_g = b[7 - (j % 8)];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predictor: a transaction occupies fixed cycle windows measured from its accept cycle.
  int          m_acc [2];
  int          m_free [2];
  int          m_last [2];
  int          m_port [2];
  logic [31:0] m_word [2];
  logic [31:0] m_rd0 [2];
  logic [31:0] m_rd1 [2];
  int          cs_run [2];
  int          cs_last_run [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = -1; m_free[i] = 0; m_last[i] = 1; m_port[i] = 0;
      m_word[i] = '0; m_rd0[i] = '0; m_rd1[i] = '0;
      cs_run[i] = 0; cs_last_run[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_acc[i] = -1; m_free[i] = 0; m_last[i] = 1;
          m_rd0[i] = '0; m_rd1[i] = '0; cs_run[i] = 0;
          check($sformatf("i%0d c%0d reset cs", i, cyc), cs[i], 1);
          check($sformatf("i%0d c%0d reset sck", i, cyc), sck[i], 0);
          check($sformatf("i%0d c%0d reset sdo", i, cyc), sdo[i], 0);
          check($sformatf("i%0d c%0d reset busy", i, cyc), busy[i], 0);
          check($sformatf("i%0d c%0d reset rdy0", i, cyc), rdy0[i], 0);
          check($sformatf("i%0d c%0d reset rdy1", i, cyc), rdy1[i], 0);
          check($sformatf("i%0d c%0d reset rv0", i, cyc), rv0[i], 0);
          check($sformatf("i%0d c%0d reset rv1", i, cyc), rv1[i], 0);
          check($sformatf("i%0d c%0d reset rd0", i, cyc), rd0[i], 0);
          check($sformatf("i%0d c%0d reset rd1", i, cyc), rd1[i], 0);
        end else begin
          int   len, k, b;
          logic idle, eg0, eg1, in_shift, ecs, esck, ebusy, done;
          len      = 128 * div_of(i);
          idle     = (cyc >= m_free[i]);
          eg0      = idle && v0[i] && (!v1[i] || m_last[i] == 1);
          eg1      = idle && v1[i] && (!v0[i] || m_last[i] == 0);
          k        = (m_acc[i] >= 0) ? cyc - m_acc[i] - 1 : -1;
          in_shift = (k >= 0) && (k < len);
          ecs      = !in_shift;
          esck     = in_shift && (((k / div_of(i)) % 2) == 1);
          ebusy    = (k >= 0) && (cyc < m_free[i]);
          done     = (k == len);
          if (done && m_port[i] == 0) m_rd0[i] = fword(m_word[i][23:0]);
          if (done && m_port[i] == 1) m_rd1[i] = fword(m_word[i][23:0]);
          check($sformatf("i%0d c%0d rdy0", i, cyc), rdy0[i], eg0);
          check($sformatf("i%0d c%0d rdy1", i, cyc), rdy1[i], eg1);
          check($sformatf("i%0d c%0d cs", i, cyc), cs[i], ecs);
          check($sformatf("i%0d c%0d sck", i, cyc), sck[i], esck);
          check($sformatf("i%0d c%0d busy", i, cyc), busy[i], ebusy);
          check($sformatf("i%0d c%0d rv0", i, cyc), rv0[i], done && m_port[i] == 0);
          check($sformatf("i%0d c%0d rv1", i, cyc), rv1[i], done && m_port[i] == 1);
          check($sformatf("i%0d c%0d rd0", i, cyc), rd0[i], m_rd0[i]);
          check($sformatf("i%0d c%0d rd1", i, cyc), rd1[i], m_rd1[i]);
          if (in_shift) begin
            b = k / (2 * div_of(i));
            if (b < 32) check($sformatf("i%0d c%0d sdo bit%0d", i, cyc, b), sdo[i], m_word[i][31-b]);
          end
          if (eg0 || eg1) begin
            m_acc[i]  = cyc;
            m_port[i] = eg1 ? 1 : 0;
            m_word[i] = {8'h03, eg1 ? a1[i] : a0[i]};
            m_free[i] = cyc + 1 + len + gap_of(i);
            m_last[i] = m_port[i];
          end
          if (cs[i]) cs_run[i]++;
          else begin
            if (cs_run[i] > 0) cs_last_run[i] = cs_run[i];
            cs_run[i] = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int p, input logic v, input logic [23:0] a);
    if (p == 0) begin v0[i] = v; a0[i] = a; end
    else begin v1[i] = v; a1[i] = a; end
  endtask

  task automatic wait_accept(input int i, input int p, output int acc);
    acc = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((p == 0) ? rdy0[i] : rdy1[i]) begin
        acc = cyc;
        break;
      end
    end
    check($sformatf("accept seen i%0d p%0d", i, p), 32'(acc >= 0), 1);
  endtask

  task automatic wait_rsp(input int i, input int p, output int rc);
    rc = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((p == 0) ? rv0[i] : rv1[i]) begin
        rc = cyc;
        break;
      end
    end
    check($sformatf("response seen i%0d p%0d", i, p), 32'(rc >= 0), 1);
  endtask

  task automatic do_req(input int i, input int p, input logic [23:0] a, output int acc);
    @(posedge clk); #1;
    set_req(i, p, 1'b1, a);
    wait_accept(i, p, acc);
    @(posedge clk); #1;
    set_req(i, p, 1'b0, a);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int          acc, acc2, rc, ng;
    int          gport [4];
    int          gacc [4];
    logic        s_a, s_b;
    logic [31:0] lone_exp [3];
    lone_exp[0] = 32'h43424140;
    lone_exp[1] = 32'h47464544;
    lone_exp[2] = 32'h4B4A4948;

    clk   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; a0[i] = '0; a1[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset cs_no", cs[0], 1);
    check("post-reset busy", busy[0], 0);
    check("post-reset sck", sck[0], 0);

    // Single read from 0x200000.
    do_req(0, 0, 24'h200000, acc);
    wait_rsp(0, 0, rc);
    check("single latency", 32'(rc - acc), 257);
    check("single rdata", rd0[0], 32'h00000013);
    check("single cmd+addr on sdo", g_inst[0].fcap, 32'h03200000);

    // Both ports requesting from reset: alternating grants starting with port 0.
    do_reset();
    @(posedge clk); #1;
    a0[0] = 24'h000000; a1[0] = 24'h000100; v0[0] = 1'b1; v1[0] = 1'b1;
    ng = 0;
    for (int n = 0; n < 2000 && ng < 4; n++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin
        gport[ng] = rdy1[0] ? 1 : 0;
        gacc[ng]  = cyc;
        ng++;
        @(posedge clk); #1;
        if (gport[ng-1] == 0) a0[0] = a0[0] + 24'd4;
        else                  a1[0] = a1[0] + 24'd4;
        if (ng == 4) begin v0[0] = 1'b0; v1[0] = 1'b0; end
      end
    end
    check("simul grant count", ng, 4);
    for (int k = 0; k < ng; k++) check($sformatf("simul grant %0d", k), gport[k], k % 2);
    if (ng >= 2) check("simul accept spacing", 32'(gacc[1] - gacc[0]), 261);
    wait_rsp(0, 1, rc);
    check("simul last port1 rdata", rd1[0], 32'h47464544);

    // Lone requester on port 1, three consecutive words.
    for (int k = 0; k < 3; k++) begin
      do_req(0, 1, 24'(4 * k), acc);
      wait_rsp(0, 1, rc);
      check($sformatf("lone rdata %0d", k), rd1[0], lone_exp[k]);
    end
    check("lone cs_no gap >= 4", 32'(cs_last_run[0] >= 4), 1);

    // Reset in the middle of a transaction.
    do_req(0, 0, 24'h000040, acc);
    while (cyc < acc + 100) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("midreset cs_no", cs[0], 1);
    check("midreset sck", sck[0], 0);
    check("midreset busy", busy[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, 0, 24'h000010, acc);
    wait_rsp(0, 0, rc);
    check("post-reset latency", 32'(rc - acc), 257);
    check("post-reset rdata", rd0[0], 32'h53525150);

    // Port 1 raised while port 0 is busy; address changes before acceptance.
    do_req(0, 0, 24'h000020, acc);
    while (cyc < acc + 5) begin @(posedge clk); #1; end
    v1[0] = 1'b1; a1[0] = 24'h000100;
    while (cyc < acc + 50) begin @(posedge clk); #1; end
    a1[0] = 24'h000104;
    wait_accept(0, 1, acc2);
    check("held accept cycle", 32'(acc2 - acc), 261);
    check("held port0 rdata", rd0[0], 32'h63626160);
    @(posedge clk); #1 v1[0] = 1'b0;
    wait_rsp(0, 1, rc);
    check("held port1 rdata", rd1[0], 32'h47464544);

    // Fast instance: CLK_DIV=1, CS_GAP=1.
    @(posedge clk); #1;
    v0[1] = 1'b1; a0[1] = 24'h000008;
    wait_accept(1, 0, acc);
    @(posedge clk); #1;
    a0[1] = 24'h00000C;
    @(negedge clk);
    s_a = sck[1];
    check("fast cs_no low", cs[1], 0);
    @(negedge clk);
    s_b = sck[1];
    check("fast sck first low", s_a, 0);
    check("fast sck then high", s_b, 1);
    wait_rsp(1, 0, rc);
    check("fast latency", 32'(rc - acc), 129);
    check("fast rdata 0", rd0[1], 32'h4B4A4948);
    wait_accept(1, 0, acc2);
    check("fast next accept", 32'(acc2 - rc), 1);
    @(posedge clk); #1 v0[1] = 1'b0;
    wait_rsp(1, 0, rc);
    check("fast rdata 1", rd0[1], 32'h4F4E4D4C);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
